// File: rtl/up_down_step_counter_if.sv
// Request/acknowledge bus of the up/down step counter: requests and operands
// travel master -> slave, acknowledges, count value and flags travel back.
interface up_down_step_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              up;
    logic              down;
    logic              load;
    logic [WIDTH-1:0]  data;
    logic [STEP_W-1:0] step;
    logic              saturate;
    logic              up_ack;
    logic              down_ack;
    logic              load_ack;
    logic [WIDTH-1:0]  counter;
    logic              at_max;
    logic              at_min;
    logic              overflow;

    modport master (
        output up, down, load, data, step, saturate,
        input  up_ack, down_ack, load_ack, counter, at_max, at_min, overflow
    );

    modport slave (
        input  up, down, load, data, step, saturate,
        output up_ack, down_ack, load_ack, counter, at_max, at_min, overflow
    );
endinterface

// File: rtl/up_down_step_counter.sv
// Four-phase handshaked up/down counter with per-request step, wrap or clamp.
// Define UP_DOWN_STEP_COUNTER_OVERFLOW_EN to build the sticky overflow flag.
module up_down_step_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    up_down_step_counter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UP_ACK   = 2'd1,
        DOWN_ACK = 2'd2,
        LOAD_ACK = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    state_t           state_reg;
    logic [WIDTH-1:0] counter_reg;
    logic             up_ack_reg;
    logic             down_ack_reg;
    logic             load_ack_reg;

    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             up_cross;
    logic             down_cross;
    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] down_next;

    // One extra bit exposes carry out of the add and borrow out of the subtract.
    assign step_ext   = {{(WIDTH + 1 - STEP_W){1'b0}}, bus.step};
    assign sum_ext    = {1'b0, counter_reg} + step_ext;
    assign diff_ext   = {1'b0, counter_reg} - step_ext;
    assign up_cross   = sum_ext[WIDTH];
    assign down_cross = diff_ext[WIDTH];

    always_comb begin
        up_next   = sum_ext[WIDTH-1:0];
        down_next = diff_ext[WIDTH-1:0];
        if (bus.saturate && up_cross) begin
            up_next = MAX_VAL;
        end
        if (bus.saturate && down_cross) begin
            down_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            counter_reg  <= '0;
            up_ack_reg   <= 1'b0;
            down_ack_reg <= 1'b0;
            load_ack_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.load) begin
                        counter_reg  <= bus.data;
                        load_ack_reg <= 1'b1;
                        state_reg    <= LOAD_ACK;
                    end else if (bus.up) begin
                        counter_reg  <= up_next;
                        up_ack_reg   <= 1'b1;
                        state_reg    <= UP_ACK;
                    end else if (bus.down) begin
                        counter_reg  <= down_next;
                        down_ack_reg <= 1'b1;
                        state_reg    <= DOWN_ACK;
                    end
                end
                // Ack states hold the count until the requester withdraws.
                UP_ACK: begin
                    if (!bus.up) begin
                        up_ack_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                DOWN_ACK: begin
                    if (!bus.down) begin
                        down_ack_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                LOAD_ACK: begin
                    if (!bus.load) begin
                        load_ack_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    up_ack_reg   <= 1'b0;
                    down_ack_reg <= 1'b0;
                    load_ack_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef UP_DOWN_STEP_COUNTER_OVERFLOW_EN
    logic overflow_reg;

    // Sticky: set by any accepted step that leaves the range, cleared by load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            if (bus.load) begin
                overflow_reg <= 1'b0;
            end else if ((bus.up && up_cross) || (!bus.up && bus.down && down_cross)) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bus.overflow = overflow_reg;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.counter  = counter_reg;
    assign bus.up_ack   = up_ack_reg;
    assign bus.down_ack = down_ack_reg;
    assign bus.load_ack = load_ack_reg;
    assign bus.at_max   = (counter_reg == MAX_VAL);
    assign bus.at_min   = (counter_reg == '0);
endmodule

// File: tb/tb_up_down_step_counter.sv
// Directed bench for up_down_step_counter (WIDTH=8, STEP_W=4); expected values
// are hand-computed, overflow expectation follows the build macro.
module tb_up_down_step_counter;
`ifdef UP_DOWN_STEP_COUNTER_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif
    localparam int K_LOAD = 0;
    localparam int K_UP   = 1;
    localparam int K_DOWN = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    up_down_step_counter_if #(.WIDTH(8), .STEP_W(4)) bus ();

    up_down_step_counter #(.WIDTH(8), .STEP_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ack_of(input int kind);
        case (kind)
            K_LOAD:  return bus.load_ack;
            K_UP:    return bus.up_ack;
            default: return bus.down_ack;
        endcase
    endfunction

    // Full handshake: raise request, check ack + count, drop request, check release.
    task automatic run_req(input string tag, input int kind, input logic [7:0] d,
                           input logic [3:0] s, input logic sat, input logic [7:0] exp_cnt);
        @(negedge clock);
        bus.data     = d;
        bus.step     = s;
        bus.saturate = sat;
        bus.load     = (kind == K_LOAD);
        bus.up       = (kind == K_UP);
        bus.down     = (kind == K_DOWN);
        @(posedge clock); #1;
        check_eq({tag, "_ack"}, 32'(ack_of(kind)), 32'd1);
        check_eq({tag, "_cnt"}, 32'(bus.counter), 32'(exp_cnt));
        @(negedge clock);
        bus.load = 1'b0;
        bus.up   = 1'b0;
        bus.down = 1'b0;
        @(posedge clock); #1;
        check_eq({tag, "_rel"}, 32'(ack_of(kind)), 32'd0);
        check_eq({tag, "_hold"}, 32'(bus.counter), 32'(exp_cnt));
        $display("txn %-10s kind=%0d data=%02h step=%0d sat=%0b -> counter=%02h ovf=%0b",
                 tag, kind, d, s, sat, bus.counter, bus.overflow);
    endtask

    initial begin
        bus.up = 1'b0; bus.down = 1'b0; bus.load = 1'b0;
        bus.data = '0; bus.step = '0; bus.saturate = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_cnt", 32'(bus.counter), 32'd0);
        check_eq("rst_acks", {29'd0, bus.up_ack, bus.down_ack, bus.load_ack}, 32'd0);
        check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
        check_eq("rst_at_min", 32'(bus.at_min), 32'd1);
        check_eq("rst_at_max", 32'(bus.at_max), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        $display("txn reset      -> counter=%02h", bus.counter);

        // Held up request must count exactly once.
        @(negedge clock);
        bus.up = 1'b1; bus.step = 4'd3; bus.saturate = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check_eq($sformatf("held_cnt%0d", i), 32'(bus.counter), 32'd3);
            check_eq($sformatf("held_ack%0d", i), 32'(bus.up_ack), 32'd1);
        end
        @(negedge clock);
        bus.up = 1'b0;
        @(posedge clock); #1;
        check_eq("held_rel", 32'(bus.up_ack), 32'd0);
        @(posedge clock); #1;
        check_eq("held_once", 32'(bus.counter), 32'd3);
        $display("txn held_up    step=3 -> counter=%02h", bus.counter);

        // Wrap past the top.
        run_req("ld254", K_LOAD, 8'd254, 4'd0, 1'b0, 8'd254);
        check_eq("ld254_ovf", 32'(bus.overflow), 32'd0);
        run_req("wrap_up", K_UP, 8'd0, 4'd5, 1'b0, 8'd3);
        check_eq("wrap_up_ovf", 32'(bus.overflow), 32'(OVF_EN));

        // Clamp at zero, then load clears overflow.
        run_req("ld2", K_LOAD, 8'd2, 4'd0, 1'b0, 8'd2);
        check_eq("ld2_ovf", 32'(bus.overflow), 32'd0);
        run_req("sat_dn", K_DOWN, 8'd0, 4'd7, 1'b1, 8'd0);
        check_eq("sat_dn_min", 32'(bus.at_min), 32'd1);
        check_eq("sat_dn_ovf", 32'(bus.overflow), 32'(OVF_EN));
        run_req("ld80", K_LOAD, 8'h80, 4'd0, 1'b0, 8'h80);
        check_eq("ld80_ovf", 32'(bus.overflow), 32'd0);

        // Clamp at top, wrap below zero, zero step.
        run_req("ld250", K_LOAD, 8'd250, 4'd0, 1'b0, 8'd250);
        run_req("sat_up", K_UP, 8'd0, 4'd15, 1'b1, 8'd255);
        check_eq("sat_up_max", 32'(bus.at_max), 32'd1);
        run_req("ld1", K_LOAD, 8'd1, 4'd0, 1'b0, 8'd1);
        run_req("wrap_dn", K_DOWN, 8'd0, 4'd3, 1'b0, 8'd254);
        check_eq("wrap_dn_ovf", 32'(bus.overflow), 32'(OVF_EN));
        run_req("step0", K_UP, 8'd0, 4'd0, 1'b0, 8'd254);

        // All three requests at once: load, then up, then down.
        @(negedge clock);
        bus.data = 8'h10; bus.step = 4'd2; bus.saturate = 1'b0;
        bus.load = 1'b1; bus.up = 1'b1; bus.down = 1'b1;
        @(posedge clock); #1;
        check_eq("pri_ld_ack", 32'(bus.load_ack), 32'd1);
        check_eq("pri_ld_upack", 32'(bus.up_ack), 32'd0);
        check_eq("pri_ld_cnt", 32'(bus.counter), 32'h10);
        @(negedge clock); bus.load = 1'b0;
        @(posedge clock); #1;
        check_eq("pri_ld_rel", 32'(bus.load_ack), 32'd0);
        check_eq("pri_idle_cnt", 32'(bus.counter), 32'h10);
        @(posedge clock); #1;
        check_eq("pri_up_ack", 32'(bus.up_ack), 32'd1);
        check_eq("pri_up_dnack", 32'(bus.down_ack), 32'd0);
        check_eq("pri_up_cnt", 32'(bus.counter), 32'h12);
        @(negedge clock); bus.up = 1'b0;
        @(posedge clock); #1;
        check_eq("pri_up_rel", 32'(bus.up_ack), 32'd0);
        check_eq("pri_wait_dn", 32'(bus.down_ack), 32'd0);
        @(posedge clock); #1;
        check_eq("pri_dn_ack", 32'(bus.down_ack), 32'd1);
        check_eq("pri_dn_cnt", 32'(bus.counter), 32'h10);
        @(negedge clock); bus.down = 1'b0;
        @(posedge clock); #1;
        check_eq("pri_dn_rel", 32'(bus.down_ack), 32'd0);
        $display("txn priority   load/up/down -> counter=%02h", bus.counter);

        // Asynchronous reset in the middle of UP_ACK, request still held on release.
        run_req("ld20", K_LOAD, 8'h20, 4'd0, 1'b0, 8'h20);
        @(negedge clock);
        bus.up = 1'b1; bus.step = 4'd4; bus.saturate = 1'b0;
        @(posedge clock); #1;
        check_eq("ar_pre_cnt", 32'(bus.counter), 32'h24);
        #2 reset = 1'b1;
        #1;
        check_eq("ar_cnt", 32'(bus.counter), 32'd0);
        check_eq("ar_ack", 32'(bus.up_ack), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check_eq("ar_re_cnt", 32'(bus.counter), 32'd4);
        check_eq("ar_re_ack", 32'(bus.up_ack), 32'd1);
        @(negedge clock); bus.up = 1'b0;
        @(posedge clock); #1;
        check_eq("ar_rel", 32'(bus.up_ack), 32'd0);
        $display("txn async_rst  -> counter=%02h", bus.counter);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
